// File: rtl/nibble_pack_writer.sv
// nibble_pack_writer
//
// Write-side packer for the 4-bit-pixel frame buffer. Accepts a stream of
// 4-bit palette indices starting at a 20-bit nibble address, packs them four
// per 16-bit word (nibble n in bits [4n+3:4n], n = nibble_addr[1:0]) and
// issues masked word writes on an 18-bit word-addressed write port.
// Unaligned starts, partial final words and wrap at 2^20 nibbles are handled.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high; aborts any transfer
//   start      one-cycle transfer request, honoured only in IDLE
//   base_addr  nibble address of the first pixel (latched on start)
//   length     pixel count (latched on start); zero is legal
//   pix_data   pixel palette index
//   pix_valid  pix_data valid this cycle
//   pix_ready  pixel accepted this cycle when high together with pix_valid
//   wr_en      one-cycle word write strobe
//   wr_addr    word address of the write
//   wr_data    packed word; nibbles outside wr_mask are 0
//   wr_mask    nibble write enables, bit n covers wr_data[4n+3:4n]
//   busy       high whenever a transfer is in progress (state != IDLE)
//   done       one-cycle pulse at the end of a transfer
module nibble_pack_writer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [19:0] base_addr,
  input  logic [19:0] length,
  input  logic [3:0]  pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        wr_en,
  output logic [17:0] wr_addr,
  output logic [15:0] wr_data,
  output logic [3:0]  wr_mask,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [19:0] cur_addr;
  logic [19:0] remaining;
  logic [15:0] pack_buf;
  logic [3:0]  pack_mask;

  logic        accept;
  logic        last_pix;
  logic        emit;
  logic [1:0]  nib;
  logic [3:0]  nib_shift;
  logic [15:0] buf_ins;
  logic [3:0]  mask_ins;

  // Input stage: merge the incoming pixel into the partial word
  assign accept    = pix_valid & pix_ready;
  assign nib       = cur_addr[1:0];
  assign nib_shift = {nib, 2'b00};
  assign last_pix  = (remaining == 20'd1);
  // A word is flushed when its top nibble is filled or the stream ends.
  assign emit      = (nib == 2'd3) | last_pix;
  assign buf_ins   = (pack_buf & ~(16'h000F << nib_shift)) |
                     ({12'h000, pix_data} << nib_shift);
  assign mask_ins  = pack_mask | (4'b0001 << nib);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pix_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (length == 20'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        pix_ready = 1'b1;
        if (pix_valid && last_pix) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output stage: registered word write, held between strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_addr  <= 20'd0;
      remaining <= 20'd0;
      pack_buf  <= 16'd0;
      pack_mask <= 4'd0;
      wr_en     <= 1'b0;
      wr_addr   <= 18'd0;
      wr_data   <= 16'd0;
      wr_mask   <= 4'd0;
    end else begin
      wr_en <= 1'b0;
      if (state == S_IDLE && start) begin
        cur_addr  <= base_addr;
        remaining <= length;
        pack_buf  <= 16'd0;
        pack_mask <= 4'd0;
      end else if (accept) begin
        // Increment wraps naturally at 2^20; the wrap always lands on a
        // word boundary, so no word ever straddles it.
        cur_addr  <= cur_addr + 20'd1;
        remaining <= remaining - 20'd1;
        if (emit) begin
          wr_en     <= 1'b1;
          wr_addr   <= cur_addr[19:2];
          wr_data   <= buf_ins;
          wr_mask   <= mask_ins;
          pack_buf  <= 16'd0;
          pack_mask <= 4'd0;
        end else begin
          pack_buf  <= buf_ins;
          pack_mask <= mask_ins;
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_pack_writer.sv
// Testbench for nibble_pack_writer: directed scenarios with literal
// expectations plus randomized transfers checked every cycle against a
// behavioural model of the packer.
module tb_nibble_pack_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [19:0] base_addr = 20'd0;
  logic [19:0] length = 20'd0;
  logic [3:0]  pix_data = 4'd0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        wr_en;
  logic [17:0] wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  wr_mask;
  logic        busy;
  logic        done;

  nibble_pack_writer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_mask   (wr_mask),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;
  int n_busy = 0;
  int n_dw   = 0;
  bit mon_on = 1'b0;
  logic [37:0] wlog[$];
  logic [3:0]  tbl[32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Pixels of the word currently being gathered; a word's contents are the
  // sum of its pixels placed at their nibble positions.
  typedef struct packed { logic [19:0] a; logic [3:0] p; } pix_t;
  pix_t        grp[$];
  int          m_phase = 0;          // 0 idle, 1 taking pixels, 2 finishing
  logic [19:0] m_addr = 20'd0;
  int          m_left = 0;
  logic        e_wr_en = 1'b0;
  logic [17:0] e_addr = 18'd0;
  logic [15:0] e_data = 16'd0;
  logic [3:0]  e_mask = 4'd0;

  task automatic model_step();
    if (reset) begin
      m_phase = 0; m_left = 0; grp.delete();
      e_wr_en = 1'b0; e_addr = 18'd0; e_data = 16'd0; e_mask = 4'd0;
    end else begin
      e_wr_en = 1'b0;
      if (m_phase == 0) begin
        if (start) begin
          m_addr = base_addr;
          m_left = int'(length);
          grp.delete();
          m_phase = (length == 20'd0) ? 2 : 1;
        end
      end else if (m_phase == 1) begin
        if (pix_valid) begin
          grp.push_back('{a: m_addr, p: pix_data});
          if (m_addr % 4 == 3 || m_left == 1) begin
            e_data = 16'd0;
            e_mask = 4'd0;
            foreach (grp[i]) begin
              e_data = e_data | (16'(grp[i].p) << (4 * (grp[i].a % 4)));
              e_mask = e_mask | 4'(1 << (grp[i].a % 4));
            end
            e_wr_en = 1'b1;
            e_addr  = m_addr[19:2];
            grp.delete();
          end
          m_addr = m_addr + 20'd1;
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    logic [41:0] act;
    logic [41:0] exp;
    @(negedge clk);
    if (mon_on) begin
      exp = {m_phase == 1, m_phase != 0, m_phase == 2, e_wr_en, e_addr, e_data, e_mask};
      act = {pix_ready, busy, done, wr_en, wr_addr, wr_data, wr_mask};
      check("outputs{rdy,busy,done,wr_en,addr,data,mask}", 64'(act), 64'(exp));
      if (wr_en) wlog.push_back({wr_addr, wr_data, wr_mask});
      if (done) n_done++;
      if (busy) n_busy++;
      if (done && wr_en) n_dw++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input logic [19:0] b, input logic [19:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 20'($urandom); length = 20'($urandom);
  endtask

  // vpct < 0 selects strict 1/0 toggling of pix_valid.
  task automatic feed(input int n, input int vpct, input bit use_tbl, input bit poke);
    int idx = 0;
    int cyc = 0;
    logic rdy;
    while (idx < n && cyc < 4000) begin
      if (vpct < 0) pix_valid = (cyc % 2 == 0);
      else pix_valid = (int'($urandom_range(99)) < vpct);
      pix_data = use_tbl ? tbl[idx] : 4'($urandom);
      if (poke) begin
        start = 1'($urandom_range(1));
        base_addr = 20'($urandom);
        length = 20'($urandom);
      end
      @(negedge clk); rdy = pix_ready;
      @(posedge clk); #1;
      if (pix_valid && rdy) idx++;
      cyc++;
    end
    pix_valid = 1'b0;
    start = 1'b0;
    check("pixels_accepted_within_budget", 64'(idx), 64'(n));
  endtask

  task automatic check_wr(input string name, input int idx, input logic [37:0] exp);
    logic [37:0] got;
    got = (idx < wlog.size()) ? wlog[idx] : 38'hx;
    check(name, 64'(got), 64'(exp));
  endtask

  task automatic aligned_test();
    int d0, dw0;
    wlog.delete(); d0 = n_done; dw0 = n_dw;
    for (int i = 0; i < 8; i++) tbl[i] = 4'(i + 1);
    do_start(20'h00010, 20'd8);
    feed(8, 100, 1'b1, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("aligned_nwrites", 64'(wlog.size()), 64'd2);
    check_wr("aligned_wr0", 0, {18'h00004, 16'h4321, 4'b1111});
    check_wr("aligned_wr1", 1, {18'h00005, 16'h8765, 4'b1111});
    check("aligned_done", 64'(n_done - d0), 64'd1);
    check("aligned_done_with_wr", 64'(n_dw - dw0), 64'd1);
  endtask

  initial begin
    int d0, b0;
    #1 reset = 1'b1;
    mon_on = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'({pix_ready, busy, done, wr_en, wr_addr, wr_data, wr_mask}), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    aligned_test();

    // Unaligned partial word
    wlog.delete();
    tbl[0] = 4'hA; tbl[1] = 4'hB; tbl[2] = 4'hC;
    do_start(20'h00001, 20'd3);
    feed(3, 100, 1'b1, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("unaligned_nwrites", 64'(wlog.size()), 64'd1);
    check_wr("unaligned_wr0", 0, {18'h00000, 16'hCBA0, 4'b1110});

    // Address wrap
    wlog.delete();
    for (int i = 0; i < 4; i++) tbl[i] = 4'(i + 1);
    do_start(20'hFFFFE, 20'd4);
    feed(4, 100, 1'b1, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("wrap_nwrites", 64'(wlog.size()), 64'd2);
    check_wr("wrap_wr0", 0, {18'h3FFFF, 16'h2100, 4'b1100});
    check_wr("wrap_wr1", 1, {18'h00000, 16'h0043, 4'b0011});

    // Valid gaps with start re-pulsed mid-run
    wlog.delete();
    do_start(20'h00000, 20'd4);
    feed(4, -1, 1'b1, 1'b1);
    repeat (3) @(posedge clk); #1;
    check("gaps_nwrites", 64'(wlog.size()), 64'd1);
    check_wr("gaps_wr0", 0, {18'h00000, 16'h4321, 4'b1111});

    // Zero length
    wlog.delete(); d0 = n_done; b0 = n_busy;
    do_start(20'h00123, 20'd0);
    repeat (3) @(posedge clk); #1;
    check("zero_len_nwrites", 64'(wlog.size()), 64'd0);
    check("zero_len_done", 64'(n_done - d0), 64'd1);
    check("zero_len_busy_cycles", 64'(n_busy - b0), 64'd1);

    // Reset mid-transfer after six pixels
    wlog.delete(); d0 = n_done;
    for (int i = 0; i < 8; i++) tbl[i] = 4'(i + 1);
    do_start(20'h00000, 20'd8);
    feed(6, 100, 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("reset_abort_outputs", 64'({pix_ready, busy, done, wr_en, wr_addr, wr_data, wr_mask}), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset_abort_nwrites", 64'(wlog.size()), 64'd1);
    check_wr("reset_abort_wr0", 0, {18'h00000, 16'h4321, 4'b1111});
    check("reset_abort_no_done", 64'(n_done - d0), 64'd0);

    aligned_test();

    // Randomized transfers, checked cycle by cycle against the model
    for (int t = 0; t < 60; t++) begin
      logic [19:0] b;
      int l;
      b = ($urandom_range(3) == 0) ? 20'hFFFF0 + 20'($urandom_range(15)) : 20'($urandom);
      l = int'($urandom_range(20));
      do_start(b, 20'(l));
      if (l > 0) feed(l, int'($urandom_range(100, 30)), 1'b0, 1'($urandom_range(1)));
      repeat (3) @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nibble_pack_writer.md
# nibble_pack_writer

Write-side counterpart of the 4-bit-pixel on-chip memory: accepts a stream of 4-bit palette indices addressed by a 20-bit nibble address, packs them four per 16-bit word (nibble `n` in bits `[4n+3:4n]`, `n` = nibble_addr[1:0]) and issues masked word writes on an 18-bit word-addressed write port. It sits between the sprite/frame compositor and a dual-port frame-buffer RAM whose read port serves the nibble-select reader. It handles unaligned start addresses, partial final words and address wrap-around.

## Interface
Parameters: none (widths fixed by the memory format).

- clk  in  1  single system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE
- base_addr  in  20  nibble address of first pixel; latched on accepted start
- length  in  20  pixel count; latched on accepted start; 0 legal
- pix_data  in  4  pixel palette index
- pix_valid  in  1  pix_data valid this cycle
- pix_ready  out  1  block accepts pixel this cycle; combinational, high only in RUN
- wr_en  out  1  word write strobe, one cycle per word
- wr_addr  out  18  word address (nibble_addr[19:2])
- wr_data  out  16  packed word; unmasked nibbles driven 0
- wr_mask  out  4  nibble write enables, bit n ↔ wr_data[4n+3:4n]
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse at end of transfer

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches cur_addr←base_addr, remaining←length, clears pack buffer and mask. If length≠0, go to RUN; otherwise go to DONE with no write.
- RUN: a pixel is accepted on a cycle with pix_valid & pix_ready. Accepting a pixel writes pix_data into buffer nibble cur_addr[1:0], sets the matching mask bit, increments cur_addr mod 2^20 and decrements remaining.
- Word emit: on acceptance, if cur_addr[1:0]==3 or this is the last pixel (remaining==1), register wr_en=1, wr_addr=cur_addr[19:2] (pre-increment), wr_data=buffer including new nibble, wr_mask=mask including new bit. Then clear the buffer and mask.
- Last pixel accepted moves RUN→DONE.
- DONE: done=1 for exactly one cycle, then →IDLE.
- Cycles with pix_valid=0 in RUN do nothing; there is no timeout.
- start outside IDLE is ignored. base_addr and length are not re-sampled mid-transfer.
- Wrap: cur_addr 0xFFFFF+1 → 0x00000. A word straddling the wrap is not possible, since wrap occurs on a word boundary.
- The memory port accepts a write every cycle; the block has no write back-pressure.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, wr_mask=0, pix_ready=0, busy=0, done=0, state=IDLE.
- Reset asserted mid-transfer aborts immediately. No further wr_en, buffered nibbles are discarded, and done is not pulsed.
- start accepted at cycle T → busy=1 and pix_ready=1 from T+1 (length≠0).
- Pixel accepted at cycle C that completes a word → wr_en high during C+1 only. Back-to-back words are possible: one write per 4 accepted pixels, up to one write per cycle in the unaligned-start case.
- Last pixel accepted at C → during C+1: state DONE, pix_ready=0, final wr_en=1, done=1, busy=1. At C+2: IDLE, busy=0.
- length=0, start at T → during T+1: DONE, done=1, busy=1, wr_en=0. At T+2: IDLE.
- wr_* outputs are registered and hold their last values when wr_en=0. Only wr_en qualifies them.
- Earliest new start after done: the cycle the block is back in IDLE (C+2).

## Test plan
- Aligned run: base=0x00010, length=8, pixels 1..8 on consecutive cycles. Expect two writes: addr 0x00004 data 0x4321 mask 1111, then addr 0x00005 data 0x8765 mask 1111. done is pulsed in the cycle of the second write.
- Unaligned partial: base=0x00001, length=3, pixels A,B,C. Expect a single write at addr 0x00000, data 0xCBA0, mask 1110.
- Wrap: base=0xFFFFE, length=4, pixels 1,2,3,4. Expect a write at addr 0x3FFFF, data 0x2100, mask 1100, then a write at addr 0x00000, data 0x0043, mask 0011.
- Valid gaps and start-while-busy: base=0, length=4, pix_valid toggling 1/0, with start re-pulsed mid-run. Expect one write at addr 0, data 0x4321 (pixels 1..4), mask 1111, and base and length unchanged by the second start.
- Zero length: start with length=0. Expect done at T+1, no wr_en, and busy high for exactly one cycle.
- Reset mid-operation: base=0, length=8, assert reset after 6 pixels are accepted. Expect only the first word written, all outputs return to reset values, no done, and a fresh transfer afterwards behaves normally.
